// File: rtl/dht11_poll_ctrl_if.sv
// Signal bundle between the DHT11 poll sequencer and its environment
// (host request side plus the single-wire receiver that decodes the frame).
interface dht11_poll_ctrl_if;
    logic       start_req;
    logic       auto_en;
    logic       sensor_oe;
    logic       rx_rst_n;
    logic       rx_data_valid;
    logic [7:0] rx_rh_int;
    logic [7:0] rx_t_int;
    logic       busy;
    logic       read_ok;
    logic       read_fail;
    logic [7:0] rh_last;
    logic [7:0] t_last;
    logic [1:0] retry_cnt;
    logic [7:0] err_count;

    // Environment: issues requests and presents the receiver's decoded bytes.
    modport master (
        output start_req, auto_en, rx_data_valid, rx_rh_int, rx_t_int,
        input  sensor_oe, rx_rst_n, busy, read_ok, read_fail,
               rh_last, t_last, retry_cnt, err_count
    );

    // Sequencer: drives the sensor line, receiver reset and status.
    modport slave (
        input  start_req, auto_en, rx_data_valid, rx_rh_int, rx_t_int,
        output sensor_oe, rx_rst_n, busy, read_ok, read_fail,
               rh_last, t_last, retry_cnt, err_count
    );
endinterface

// File: rtl/dht11_poll_ctrl.sv
// DHT11 read sequencer: host start pulse, receiver arming, timeout/retry with
// sensor rest time, periodic polling, and capture of the last good RH/T bytes.
module dht11_poll_ctrl #(
    parameter int unsigned START_LOW_CYC   = 900_000,
    parameter int unsigned RELEASE_CYC     = 50,
    parameter int unsigned TIMEOUT_CYC     = 500_000,
    parameter int unsigned HOLDOFF_CYC     = 50_000_000,
    parameter int unsigned POLL_PERIOD_CYC = 100_000_000,
    parameter int unsigned MAX_RETRY       = 2
) (
    input  logic             clk_50M,
    input  logic             reset,
    dht11_poll_ctrl_if.slave bus
);
    localparam int CNT_W = 27;

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] POLL_LAST    = CNT_W'(POLL_PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LD   = CNT_W'(HOLDOFF_CYC);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_LISTEN,
        S_BACKOFF
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cyc_q,       cyc_d;
    logic [CNT_W-1:0] holdoff_q,   holdoff_d;
    logic [CNT_W-1:0] poll_q,      poll_d;
    logic             pending_q,   pending_d;
    logic             sensor_oe_q, sensor_oe_d;
    logic             rx_rst_n_q,  rx_rst_n_d;
    logic             busy_q,      busy_d;
    logic             read_ok_q,   read_ok_d;
    logic             read_fail_q, read_fail_d;
    logic [7:0]       rh_q,        rh_d;
    logic [7:0]       t_q,         t_d;
    logic [1:0]       retry_q,     retry_d;
    logic [7:0]       err_q,       err_d;
    logic             poll_wrap;

    always_comb begin
        // NOTE: every *_d is given a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cyc_d       = cyc_q;
        sensor_oe_d = sensor_oe_q;
        rx_rst_n_d  = rx_rst_n_q;
        busy_d      = busy_q;
        read_ok_d   = 1'b0;
        read_fail_d = 1'b0;
        rh_d        = rh_q;
        t_d         = t_q;
        retry_d     = retry_q;
        err_d       = err_q;
        holdoff_d   = (holdoff_q != '0) ? holdoff_q - 1'b1 : holdoff_q;

        poll_wrap = bus.auto_en && (poll_q == POLL_LAST);
        if (!bus.auto_en || poll_wrap) poll_d = '0;
        else                           poll_d = poll_q + 1'b1;

        // Requests arriving while busy only arm the next transaction.
        pending_d = pending_q | bus.start_req | poll_wrap;

        unique case (state_q)
            S_IDLE: begin
                if (pending_q && holdoff_q == '0) begin
                    state_d     = S_START_LOW;
                    pending_d   = bus.start_req | poll_wrap;
                    retry_d     = '0;
                    busy_d      = 1'b1;
                    sensor_oe_d = 1'b1;
                    cyc_d       = '0;
                end
            end
            S_START_LOW: begin
                if (cyc_q == START_LAST) begin
                    state_d     = S_RELEASE;
                    sensor_oe_d = 1'b0;
                    cyc_d       = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cyc_q == RELEASE_LAST) begin
                    state_d    = S_LISTEN;
                    rx_rst_n_d = 1'b1;
                    cyc_d      = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_LISTEN: begin
                // A frame arriving on the timeout cycle still counts as a success.
                if (bus.rx_data_valid) begin
                    rh_d       = bus.rx_rh_int;
                    t_d        = bus.rx_t_int;
                    read_ok_d  = 1'b1;
                    busy_d     = 1'b0;
                    rx_rst_n_d = 1'b0;
                    holdoff_d  = HOLDOFF_LD;
                    state_d    = S_IDLE;
                end else if (cyc_q == TIMEOUT_LAST) begin
                    rx_rst_n_d = 1'b0;
                    holdoff_d  = HOLDOFF_LD;
                    if (err_q != 8'hFF) err_d = err_q + 1'b1;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_BACKOFF;
                    end else begin
                        read_fail_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_BACKOFF: begin
                if (holdoff_q == '0) begin
                    state_d     = S_START_LOW;
                    sensor_oe_d = 1'b1;
                    cyc_d       = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Async reset releases the sensor line at once and restarts the rest period.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            holdoff_q   <= HOLDOFF_LD;
            poll_q      <= '0;
            pending_q   <= 1'b0;
            sensor_oe_q <= 1'b0;
            rx_rst_n_q  <= 1'b0;
            busy_q      <= 1'b0;
            read_ok_q   <= 1'b0;
            read_fail_q <= 1'b0;
            rh_q        <= '0;
            t_q         <= '0;
            retry_q     <= '0;
            err_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            holdoff_q   <= holdoff_d;
            poll_q      <= poll_d;
            pending_q   <= pending_d;
            sensor_oe_q <= sensor_oe_d;
            rx_rst_n_q  <= rx_rst_n_d;
            busy_q      <= busy_d;
            read_ok_q   <= read_ok_d;
            read_fail_q <= read_fail_d;
            rh_q        <= rh_d;
            t_q         <= t_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
        end
    end

    assign bus.sensor_oe = sensor_oe_q;
    assign bus.rx_rst_n  = rx_rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.read_ok   = read_ok_q;
    assign bus.read_fail = read_fail_q;
    assign bus.rh_last   = rh_q;
    assign bus.t_last    = t_q;
    assign bus.retry_cnt = retry_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Bench for dht11_poll_ctrl: a sensor/receiver model answers LISTEN windows, a scoreboard
// checks each read_ok/read_fail against queued expectations, a line monitor times the pulses.
module tb_dht11_poll_ctrl;
    localparam int unsigned START_LOW_CYC   = 100;
    localparam int unsigned RELEASE_CYC     = 4;
    localparam int unsigned TIMEOUT_CYC     = 200;
    localparam int unsigned HOLDOFF_CYC     = 50;
    localparam int unsigned POLL_PERIOD_CYC = 1000;
    localparam int unsigned MAX_RETRY       = 2;
    localparam int          RESP_DLY        = 20;  // cycles into LISTEN before the model answers

    typedef struct {
        bit         ok;
        logic [7:0] rh;
        logic [7:0] t;
        logic [1:0] retry;
        logic [7:0] err;
    } exp_t;

    logic clk_50M = 1'b0;
    logic reset;
    dht11_poll_ctrl_if bus ();

    dht11_poll_ctrl #(
        .START_LOW_CYC  (START_LOW_CYC),
        .RELEASE_CYC    (RELEASE_CYC),
        .TIMEOUT_CYC    (TIMEOUT_CYC),
        .HOLDOFF_CYC    (HOLDOFF_CYC),
        .POLL_PERIOD_CYC(POLL_PERIOD_CYC),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .clk_50M(clk_50M),
        .reset  (reset),
        .bus    (bus)
    );

    initial forever #10 clk_50M = ~clk_50M;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    exp_t exp_q[$];
    int   rise_q[$];
    int   exit_q[$];

    int         listen_no = 0;
    int         fail_first = 0;
    bit         respond_en = 1'b0;
    logic [7:0] resp_rh = 8'h00;
    logic [7:0] resp_t = 8'h00;
    int         stray_cnt = 0;

    initial forever begin
        @(posedge clk_50M);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic int rise_at(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -100000;
    endfunction

    function automatic int exit_at(input int i);
        return (i < exit_q.size()) ? exit_q[i] : 100000;
    endfunction

    task automatic expect_rd(input bit ok, input logic [7:0] rh, input logic [7:0] t,
                             input logic [1:0] retry, input logic [7:0] err);
        exp_t e;
        e.ok = ok; e.rh = rh; e.t = t; e.retry = retry; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sensor_oe"}, bus.sensor_oe, 1'b0);
        check({tag, "_rx_rst_n"},  bus.rx_rst_n,  1'b0);
        check({tag, "_busy"},      bus.busy,      1'b0);
        check({tag, "_read_ok"},   bus.read_ok,   1'b0);
        check({tag, "_read_fail"}, bus.read_fail, 1'b0);
        check({tag, "_rh_last"},   bus.rh_last,   8'h00);
        check({tag, "_t_last"},    bus.t_last,    8'h00);
        check({tag, "_retry_cnt"}, bus.retry_cnt, 2'd0);
        check({tag, "_err_count"}, bus.err_count, 8'd0);
    endtask

    // Reset asserted between edges: the line must drop without waiting for a clock.
    task automatic do_reset();
        @(negedge clk_50M);
        #2 reset = 1'b0;
        #1 check_reset_vals("rst_async");
        repeat (3) @(negedge clk_50M);
        check_reset_vals("rst_held");
        #2 reset = 1'b1;
        rel_cyc = cyc;
    endtask

    // Returns the edge number on which the DUT samples start_req.
    task automatic pulse_start(output int s);
        @(negedge clk_50M);
        bus.start_req = 1'b1;
        @(negedge clk_50M);
        bus.start_req = 1'b0;
        s = cyc;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_oe(input int budget, input string name);
        int n = 0;
        while (!bus.sensor_oe && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        check(name, bus.sensor_oe, 1'b1);
    endtask

    // Sensor + receiver model: answers the LISTEN windows after the first fail_first ones.
    initial begin : responder
        int age;
        bit prev_listen;
        int stray_done;
        age = 0; prev_listen = 1'b0; stray_done = 0;
        bus.rx_data_valid = 1'b0;
        bus.rx_rh_int = 8'h00;
        bus.rx_t_int  = 8'h00;
        forever begin
            @(negedge clk_50M);
            bus.rx_data_valid = 1'b0;
            if (bus.rx_rst_n === 1'b1 && !prev_listen) begin
                listen_no++;
                age = 0;
            end else if (bus.rx_rst_n === 1'b1) begin
                age++;
            end
            if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                bus.rx_data_valid = 1'b1;
                bus.rx_rh_int = 8'hEE;
                bus.rx_t_int  = 8'hEE;
            end else if (bus.rx_rst_n === 1'b1 && respond_en && age == RESP_DLY && listen_no > fail_first) begin
                bus.rx_data_valid = 1'b1;
                bus.rx_rh_int = resp_rh;
                bus.rx_t_int  = resp_t;
            end
            prev_listen = (bus.rx_rst_n === 1'b1);
        end
    end

    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk_50M);
            if (reset === 1'b1 && (bus.read_ok === 1'b1 || bus.read_fail === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: actual read_ok=%0b read_fail=%0b at cycle %0d, required no output",
                             bus.read_ok, bus.read_fail, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_read_ok",   bus.read_ok,   e.ok);
                    check("sb_read_fail", bus.read_fail, !e.ok);
                    check("sb_rh_last",   bus.rh_last,   e.rh);
                    check("sb_t_last",    bus.t_last,    e.t);
                    check("sb_retry_cnt", bus.retry_cnt, e.retry);
                    check("sb_err_count", bus.err_count, e.err);
                    check("sb_busy",      bus.busy,      1'b0);
                    check("sb_rx_rst_n",  bus.rx_rst_n,  1'b0);
                end
            end
        end
    end

    // Line monitor: start-low and release lengths, plus edge log of pulses and LISTEN exits.
    initial begin : line_mon
        bit prev_oe, prev_rx, in_pulse, in_release;
        int t_rise, t_fall;
        prev_oe = 0; prev_rx = 0; in_pulse = 0; in_release = 0; t_rise = 0; t_fall = 0;
        forever begin
            @(negedge clk_50M);
            if (reset !== 1'b1) begin
                prev_oe = 0; prev_rx = 0; in_pulse = 0; in_release = 0;
            end else begin
                if (bus.sensor_oe && !prev_oe) begin
                    rise_q.push_back(cyc);
                    t_rise = cyc;
                    in_pulse = 1;
                end
                if (!bus.sensor_oe && prev_oe && in_pulse) begin
                    check("start_low_len", cyc - t_rise, START_LOW_CYC);
                    t_fall = cyc;
                    in_pulse = 0;
                    in_release = 1;
                end
                if (bus.rx_rst_n && !prev_rx && in_release) begin
                    check("release_len", cyc - t_fall, RELEASE_CYC);
                    in_release = 0;
                end
                if (!bus.rx_rst_n && prev_rx) exit_q.push_back(cyc);
                prev_oe = bus.sensor_oe;
                prev_rx = bus.rx_rst_n;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual run still active at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s;
        int n_extra;
        reset = 1'b0;
        bus.start_req = 1'b0;
        bus.auto_en   = 1'b0;
        do_reset();

        // Post-reset request waits out the holdoff, then one good frame 0x37/0x19.
        respond_en = 1'b1; fail_first = listen_no; resp_rh = 8'h37; resp_t = 8'h19;
        rise_q.delete(); exit_q.delete();
        repeat (9) @(negedge clk_50M);
        expect_rd(1'b1, 8'h37, 8'h19, 2'd0, 8'd0);
        pulse_start(s);
        wait_drain(600, "t1_drain");
        check("t1_pulse_count", rise_q.size(), 1);
        // Holdoff reaches 0 after HOLDOFF_CYC edges; IDLE acts on the following edge.
        check("t1_holdoff_rise", rise_at(0) - rel_cyc, HOLDOFF_CYC + 1);

        // A receiver pulse while IDLE must not be captured.
        stray_cnt++;
        repeat (10) @(negedge clk_50M);
        check("stray_rh_kept", bus.rh_last, 8'h37);
        check("stray_t_kept",  bus.t_last,  8'h19);

        // Holdoff long expired: the line rises one edge after start_req is sampled.
        repeat (60) @(negedge clk_50M);
        resp_rh = 8'h41; resp_t = 8'h16; fail_first = listen_no;
        rise_q.delete();
        expect_rd(1'b1, 8'h41, 8'h16, 2'd0, 8'd0);
        pulse_start(s);
        wait_drain(600, "imm_drain");
        check("imm_rise_latency", rise_at(0) - s, 1);

        // Sensor never answers: three attempts, then read_fail.
        do_reset();
        respond_en = 1'b0;
        rise_q.delete(); exit_q.delete();
        repeat (5) @(negedge clk_50M);
        expect_rd(1'b0, 8'h00, 8'h00, 2'd2, 8'd3);
        pulse_start(s);
        wait_drain(2500, "t3_drain");
        check("t3_pulse_count", rise_q.size(), 3);
        check("t3_exit_count",  exit_q.size(), 3);
        check("t3_gap1", rise_at(1) - exit_at(0), HOLDOFF_CYC + 1);
        check("t3_gap2", rise_at(2) - exit_at(1), HOLDOFF_CYC + 1);

        // First attempt times out, retry succeeds.
        do_reset();
        respond_en = 1'b1; fail_first = listen_no + 1; resp_rh = 8'h2A; resp_t = 8'h14;
        repeat (5) @(negedge clk_50M);
        expect_rd(1'b1, 8'h2A, 8'h14, 2'd1, 8'd1);
        pulse_start(s);
        wait_drain(1500, "t4_drain");

        // Auto-poll for ~3000 cycles: 3 polls plus one coalesced extra from 3 start_req pulses.
        do_reset();
        respond_en = 1'b1; fail_first = listen_no; resp_rh = 8'h30; resp_t = 8'h18;
        rise_q.delete();
        repeat (4) expect_rd(1'b1, 8'h30, 8'h18, 2'd0, 8'd0);
        n_extra = 0;
        @(negedge clk_50M);
        bus.auto_en = 1'b1;
        for (int i = 0; i < 3005; i++) begin
            @(negedge clk_50M);
            if (bus.start_req) bus.start_req = 1'b0;
            else if (bus.busy && n_extra < 3 && (i % 8) == 0) begin
                bus.start_req = 1'b1;
                n_extra++;
            end
        end
        bus.auto_en = 1'b0;
        bus.start_req = 1'b0;
        wait_drain(600, "t5_drain");
        repeat (1200) @(negedge clk_50M);
        check("t5_transactions", rise_q.size(), 4);

        // Reset in the middle of the start pulse.
        respond_en = 1'b1; fail_first = listen_no; resp_rh = 8'h55; resp_t = 8'h21;
        pulse_start(s);
        wait_oe(200, "t6_start_low_seen");
        repeat (30) @(negedge clk_50M);
        do_reset();
        rise_q.delete();
        repeat (4) @(negedge clk_50M);
        expect_rd(1'b1, 8'h55, 8'h21, 2'd0, 8'd0);
        pulse_start(s);
        wait_drain(600, "t6_drain");
        check("t6_holdoff_rise", rise_at(0) - rel_cyc, HOLDOFF_CYC + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
